// File: rtl/axis_pkg.sv
// Shared types for the AXI4-Stream packet generator: FSM states and beat-count sizing.
package axis_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int BURST_LEN_DEF = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [$clog2(BURST_LEN_DEF+1)-1:0] beat_cnt_t;

endpackage

// File: rtl/axis_m.sv
// AXI4-Stream master: captures a seed on newd and emits BURST_LEN beats of
// seed+index, tlast on the final beat. All outputs come straight from flops.
module axis_m
    import axis_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_areset,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic              m_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast
);

    localparam int                CNT_W    = $clog2(BURST_LEN+1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN-1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [DATA_W-1:0] seed, seed_nxt;
    logic [DATA_W-1:0] tdata_nxt;
    logic              tvalid_nxt, tlast_nxt;

    // Next-state logic also precomputes the registered outputs for the next
    // cycle, so tready never reaches the outputs combinationally.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        seed_nxt   = seed;
        tvalid_nxt = m_axis_tvalid;
        tdata_nxt  = m_axis_tdata;
        tlast_nxt  = m_axis_tlast;
        case (state)
            IDLE: begin
                tvalid_nxt = 1'b0;
                tlast_nxt  = 1'b0;
                tdata_nxt  = '0;
                if (newd) begin
                    state_nxt  = SEND;
                    seed_nxt   = din;
                    count_nxt  = '0;
                    tvalid_nxt = 1'b1;
                    tdata_nxt  = din;
                    tlast_nxt  = (LAST_CNT == '0);
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        state_nxt  = IDLE;
                        count_nxt  = '0;
                        tvalid_nxt = 1'b0;
                        tlast_nxt  = 1'b0;
                        tdata_nxt  = '0;
                    end else begin
                        count_nxt = count + CNT_W'(1);
                        tdata_nxt = seed + DATA_W'(count_nxt);
                        tlast_nxt = (count_nxt == LAST_CNT);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state         <= IDLE;
            count         <= '0;
            seed          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            seed          <= seed_nxt;
            m_axis_tvalid <= tvalid_nxt;
            m_axis_tdata  <= tdata_nxt;
            m_axis_tlast  <= tlast_nxt;
        end
    end

endmodule

// File: tb/tb_axis_m.sv
// Directed bench for axis_m: default 5-beat instance plus a BURST_LEN=1 instance.
module tb_axis_m;

    logic       clk = 1'b0;
    logic       areset;
    logic       newd, newd1;
    logic [7:0] din, din1;
    logic       tready;
    logic       tvalid, tlast, tvalid1, tlast1;
    logic [7:0] tdata, tdata1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axis_m u_dut (
        .m_axis_aclk  (clk),
        .m_axis_areset(areset),
        .newd         (newd),
        .din          (din),
        .m_axis_tready(tready),
        .m_axis_tvalid(tvalid),
        .m_axis_tdata (tdata),
        .m_axis_tlast (tlast)
    );

    axis_m #(.DATA_W(8), .BURST_LEN(1)) u_dut1 (
        .m_axis_aclk  (clk),
        .m_axis_areset(areset),
        .newd         (newd1),
        .din          (din1),
        .m_axis_tready(tready),
        .m_axis_tvalid(tvalid1),
        .m_axis_tdata (tdata1),
        .m_axis_tlast (tlast1)
    );

    // Advance one edge and settle; outputs are then stable for checking and
    // inputs written afterwards are sampled on the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ev, input logic [7:0] ed,
                       input logic el, input bit use_d);
        logic [9:0] got, want;
        got  = {tvalid, use_d ? tdata : 8'h00, tlast};
        want = {ev, use_d ? ed : 8'h00, el};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                   tag, tvalid, tdata, tlast, ev, ed, el);
        end
    endtask

    task automatic chk1(input string tag, input logic ev, input logic [7:0] ed,
                        input logic el, input bit use_d);
        logic [9:0] got, want;
        got  = {tvalid1, use_d ? tdata1 : 8'h00, tlast1};
        want = {ev, use_d ? ed : 8'h00, el};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got v=%b d=%h l=%b, want v=%b d=%h l=%b",
                   tag, tvalid1, tdata1, tlast1, ev, ed, el);
        end
    endtask

    initial begin
        logic [7:0] seed;
        logic [7:0] exp_d;

        // Reset held 10 cycles with a pending request and ready downstream.
        areset = 1'b1; newd = 1'b1; din = 8'h10; tready = 1'b1;
        newd1 = 1'b0; din1 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset", 1'b0, 8'h00, 1'b0, 1'b1);
            chk1("reset_b1", 1'b0, 8'h00, 1'b0, 1'b1);
        end
        areset = 1'b0;
        step();
        chk("post_reset_first", 1'b1, 8'h10, 1'b0, 1'b1);
        newd = 1'b0;
        for (int i = 1; i < 5; i++) begin
            step();
            exp_d = 8'h10 + 8'(i);
            chk("post_reset_beat", 1'b1, exp_d, (i == 4), 1'b1);
        end
        step();
        chk("post_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Basic packet from 8'h24.
        din = 8'h24; newd = 1'b1;
        step();
        newd = 1'b0; din = 8'hAA;
        chk("basic_b0", 1'b1, 8'h24, 1'b0, 1'b1);
        step(); chk("basic_b1", 1'b1, 8'h25, 1'b0, 1'b1);
        step(); chk("basic_b2", 1'b1, 8'h26, 1'b0, 1'b1);
        step(); chk("basic_b3", 1'b1, 8'h27, 1'b0, 1'b1);
        step(); chk("basic_b4", 1'b1, 8'h28, 1'b1, 1'b1);
        step(); chk("basic_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Backpressure on the third beat.
        din = 8'h81; newd = 1'b1;
        step(); newd = 1'b0;
        chk("bp_b0", 1'b1, 8'h81, 1'b0, 1'b1);
        step(); chk("bp_b1", 1'b1, 8'h82, 1'b0, 1'b1);
        step(); chk("bp_b2", 1'b1, 8'h83, 1'b0, 1'b1);
        tready = 1'b0;
        step(); chk("bp_hold1", 1'b1, 8'h83, 1'b0, 1'b1);
        step(); chk("bp_hold2", 1'b1, 8'h83, 1'b0, 1'b1);
        step(); chk("bp_hold3", 1'b1, 8'h83, 1'b0, 1'b1);
        tready = 1'b1;
        step(); chk("bp_b3", 1'b1, 8'h84, 1'b0, 1'b1);
        step(); chk("bp_b4", 1'b1, 8'h85, 1'b1, 1'b1);
        step(); chk("bp_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Data wraps modulo 256.
        din = 8'hFD; newd = 1'b1;
        step(); newd = 1'b0;
        chk("wrap_b0", 1'b1, 8'hFD, 1'b0, 1'b1);
        step(); chk("wrap_b1", 1'b1, 8'hFE, 1'b0, 1'b1);
        step(); chk("wrap_b2", 1'b1, 8'hFF, 1'b0, 1'b1);
        step(); chk("wrap_b3", 1'b1, 8'h00, 1'b0, 1'b1);
        step(); chk("wrap_b4", 1'b1, 8'h01, 1'b1, 1'b1);
        step(); chk("wrap_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Back-to-back with newd held; din scrambled mid-packet.
        seed = 8'($urandom);
        din  = seed; newd = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 5; i++) begin
                step();
                din   = 8'($urandom);
                exp_d = seed + 8'(i);
                chk("b2b_beat", 1'b1, exp_d, (i == 4), 1'b1);
            end
            step();
            chk("b2b_idle", 1'b0, 8'h00, 1'b0, 1'b0);
            seed = 8'($urandom);
            din  = seed;
            if (k == 4) newd = 1'b0;
        end
        step();
        chk("b2b_stop", 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset during the third beat aborts the packet.
        din = 8'h5A; newd = 1'b1;
        step(); newd = 1'b0;
        chk("mrst_b0", 1'b1, 8'h5A, 1'b0, 1'b1);
        step(); chk("mrst_b1", 1'b1, 8'h5B, 1'b0, 1'b1);
        step(); chk("mrst_b2", 1'b1, 8'h5C, 1'b0, 1'b1);
        areset = 1'b1;
        step(); chk("mrst_abort", 1'b0, 8'h00, 1'b0, 1'b1);
        areset = 1'b0;
        step(); chk("mrst_no_resume", 1'b0, 8'h00, 1'b0, 1'b0);
        din = 8'h33; newd = 1'b1;
        step(); newd = 1'b0;
        chk("mrst_new_b0", 1'b1, 8'h33, 1'b0, 1'b1);
        step(); chk("mrst_new_b1", 1'b1, 8'h34, 1'b0, 1'b1);
        step(); chk("mrst_new_b2", 1'b1, 8'h35, 1'b0, 1'b1);
        step(); chk("mrst_new_b3", 1'b1, 8'h36, 1'b0, 1'b1);
        step(); chk("mrst_new_b4", 1'b1, 8'h37, 1'b1, 1'b1);
        step(); chk("mrst_new_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Single-beat packets: every beat is last, one idle cycle between.
        din1 = 8'hC3; newd1 = 1'b1;
        step(); din1 = 8'hC4;
        chk1("b1_pkt0", 1'b1, 8'hC3, 1'b1, 1'b1);
        step(); chk1("b1_idle0", 1'b0, 8'h00, 1'b0, 1'b0);
        step(); newd1 = 1'b0;
        chk1("b1_pkt1", 1'b1, 8'hC4, 1'b1, 1'b1);
        step(); chk1("b1_idle1", 1'b0, 8'h00, 1'b0, 1'b0);
        step(); chk1("b1_stop", 1'b0, 8'h00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_m.md
Name: axis_m

Overview:
- AXI4-Stream master packet generator.
- On a `newd` request it captures an 8-bit seed from `din` and emits one fixed-length packet on the `m_axis_*` interface, with `tlast` on the final beat.
- It sits between a local data/command source and any downstream AXI4-Stream slave (FIFO, DMA, interconnect).
- Single clock domain, no internal buffering beyond the captured seed.

Parameters:
- DATA_W, 8, width of `din` and `m_axis_tdata`.
- BURST_LEN, 5, number of beats per packet; legal range 1 to 255.

Ports:
- `m_axis_aclk`  in  1  the single clock; all logic on the rising edge.
- `m_axis_areset`  in  1  synchronous, active-high reset.
- `newd`  in  1  request to start a packet; sampled only in IDLE.
- `din`  in  DATA_W  packet seed; captured with `newd`.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tdata`  out  DATA_W  beat data.
- `m_axis_tlast`  out  1  final beat of packet.

Behaviour:
- Reset: synchronous, active-high; one clock edge with reset high is sufficient.
  - Reset forces state IDLE, beat counter 0, seed register 0.
  - Outputs during and after reset: `tvalid`=0, `tlast`=0, `tdata`=0.
- Reset mid-packet: the packet is aborted; outputs are 0 on the edge after reset is sampled; no resumption.
- States: IDLE, SEND.
- IDLE:
  - `tvalid`=0, `tlast`=0.
  - If `newd`=1 at an edge: seed <= `din`, count <= 0, go to SEND.
  - `tvalid` rises on that same edge, i.e. 1-cycle latency from `newd` sample to first valid beat.
- SEND:
  - `tvalid`=1 continuously.
  - `tdata` = seed + count, modulo 2^DATA_W (wrap-around: seed 8'hFE gives FE, FF, 00, ...).
  - `tlast` = 1 iff count == BURST_LEN-1.
- Handshake:
  - A beat transfers at an edge where `tvalid`&`tready`=1.
  - On a non-final transfer, count increments.
  - On the final transfer (`tlast`=1), go to IDLE; `tvalid` and `tlast` drop on that edge.
- AXI stability: while `tvalid`=1 and `tready`=0, `tdata`/`tlast` hold constant; `tvalid` never deasserts before the transfer.
- `tready` may be asserted before `tvalid`; the master never waits on `tready` to raise `tvalid`.
- `newd` and `din` are ignored in SEND; changes to `din` during a packet do not affect it.
- Back-to-back requests: with `newd` held high, the next packet starts on the edge after returning to IDLE. There is exactly one idle cycle (`tvalid`=0) between packets, so `tlast` always produces a falling edge.
- BURST_LEN=1: the single beat has `tlast`=1.
- All outputs are registered; no combinational path from `tready` to `tvalid`/`tdata`/`tlast`.

Decomposition:
- Shared package `axis_pkg`: state enum typedef (IDLE, SEND), DATA_W default constant, beat-count typedef sized $clog2(BURST_LEN+1).
- No sub-module is needed; a single module with state register, count register, seed register and registered outputs.

Test Plan:
- Reset:
  - Stimulus: `areset`=1 for 10 cycles with `newd`=1, `tready`=1.
  - Required: `tvalid`=`tlast`=`tdata`=0 throughout; first `tvalid` appears 1 cycle after reset deasserts.
- Basic packet:
  - Stimulus: `din`=8'h24, `newd` pulse, `tready`=1.
  - Required: beats 24, 25, 26, 27, 28 on consecutive cycles; `tlast` only on 28; `tvalid` low the following cycle.
- Backpressure:
  - Stimulus: `din`=8'h81, `tready` low for 3 cycles during beat 2.
  - Required: `tdata`=83 and `tlast`=0 held stable; packet completes with 85 flagged `tlast`.
- Wrap-around:
  - Stimulus: `din`=8'hFD.
  - Required: beats FD, FE, FF, 00, 01; `tlast` on 01.
- Back-to-back:
  - Stimulus: `newd`=1 held, new random `din` per packet, 5 packets.
  - Required: each packet 5 beats with seed = `din` at its start; exactly one idle cycle between packets; `din` changes mid-packet are ignored.
- Mid-packet reset:
  - Stimulus: `areset` asserted at beat 3.
  - Required: `tvalid`/`tlast` = 0 next edge; after release, a new `newd` starts a fresh 5-beat packet from the new seed.
